// File: rtl/etapa_mem_wb.sv
// MEM stage: branch resolution, sized little-endian loads/stores on a lane-split data memory,
// MEM/WB register, and a halted-pipeline debug read port (built only when DEBUG_PORT_EN is defined).
module etapa_mem_wb #(
    parameter int NBITS     = 32,
    parameter int REGS      = 5,
    parameter int ADDR_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NBITS-1:0]     i_ALU,
    input  logic [NBITS-1:0]     i_Registro2,
    input  logic [REGS-1:0]      i_RegistroDestino,
    input  logic [NBITS-1:0]     i_Extension,
    input  logic [NBITS-1:0]     i_PCBranch,
    input  logic                 i_Cero,
    input  logic                 i_Branch,
    input  logic                 i_NBranch,
    input  logic                 i_MemWrite,
    input  logic                 i_MemRead,
    input  logic [1:0]           i_TamanoFiltro,
    input  logic [1:0]           i_TamanoFiltroL,
    input  logic                 i_ZeroExtend,
    input  logic                 i_MemToReg,
    input  logic                 i_RegWrite,
    input  logic                 i_LUI,
    input  logic                 i_Halt,
    input  logic                 i_DebugReq,
    input  logic [ADDR_BITS-1:0] i_DebugAddr,
    output logic                 o_PCSrc,
    output logic [NBITS-1:0]     o_PCBranch,
    output logic [NBITS-1:0]     o_DatoLeido,
    output logic [NBITS-1:0]     o_ALU,
    output logic [NBITS-1:0]     o_Extension,
    output logic [REGS-1:0]      o_RegistroDestino,
    output logic                 o_MemToReg,
    output logic                 o_RegWrite,
    output logic                 o_LUI,
    output logic                 o_Misalign,
    output logic [NBITS-1:0]     o_DebugData,
    output logic                 o_DebugValid
);

    localparam int LANES = NBITS / 8;
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane_sel;
    logic                 store_misaligned;
    logic                 load_misaligned;
    logic                 store_en;
    logic [NBITS-1:0]     rd_word;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [NBITS-1:0]     dato_next;
    logic                 misalign_next;

    // Address bits above the memory depth are dropped, so addresses wrap.
    assign word_idx = i_ALU[ADDR_BITS+1:2];
    assign lane_sel = i_ALU[1:0];

    assign o_PCSrc    = (i_Branch & i_Cero) | (i_NBranch & ~i_Cero);
    assign o_PCBranch = i_PCBranch;

    always_comb begin
        store_misaligned = 1'b0;
        load_misaligned  = 1'b0;
        if (i_TamanoFiltro[1])
            store_misaligned = (lane_sel != 2'b00);
        else if (i_TamanoFiltro[0])
            store_misaligned = lane_sel[0];
        if (i_TamanoFiltroL[1])
            load_misaligned = (lane_sel != 2'b00);
        else if (i_TamanoFiltroL[0])
            load_misaligned = lane_sel[0];
    end

    assign store_en = i_MemWrite & ~store_misaligned;

`ifdef DEBUG_PORT_EN
    logic [ADDR_BITS-1:0] dbg_addr_reg;
    logic [ADDR_BITS-1:0] dbg_addr_next;
    logic [NBITS-1:0]     dbg_word;
`endif

    // One byte-wide memory per lane keeps each lane's write enable independent.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE_ID = 2'(gi);

            logic [7:0] lane_mem [DEPTH];
            logic       lane_we;
            logic [7:0] lane_wdata;

            always_comb begin
                lane_we    = 1'b1;
                lane_wdata = i_Registro2[8*gi +: 8];
                if (!i_TamanoFiltro[1]) begin
                    if (i_TamanoFiltro[0]) begin
                        lane_we    = (lane_sel[1] == LANE_ID[1]);
                        lane_wdata = i_Registro2[8*(gi%2) +: 8];
                    end else begin
                        lane_we    = (lane_sel == LANE_ID);
                        lane_wdata = i_Registro2[7:0];
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (store_en && lane_we)
                    lane_mem[word_idx] <= lane_wdata;
            end

            assign rd_word[8*gi +: 8] = lane_mem[word_idx];
`ifdef DEBUG_PORT_EN
            assign dbg_word[8*gi +: 8] = lane_mem[dbg_addr_reg];
`endif
        end
    endgenerate

    assign ld_byte = rd_word[{lane_sel, 3'b000} +: 8];
    assign ld_half = lane_sel[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        dato_next = rd_word;
        if (!i_TamanoFiltroL[1]) begin
            if (i_TamanoFiltroL[0])
                dato_next = i_ZeroExtend ? NBITS'(ld_half) : NBITS'($signed(ld_half));
            else
                dato_next = i_ZeroExtend ? NBITS'(ld_byte) : NBITS'($signed(ld_byte));
        end
        if (!i_MemRead || load_misaligned)
            dato_next = '0;
        misalign_next = (i_MemWrite & store_misaligned) | (i_MemRead & load_misaligned);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_DatoLeido       <= '0;
            o_ALU             <= '0;
            o_Extension       <= '0;
            o_RegistroDestino <= '0;
            o_MemToReg        <= 1'b0;
            o_RegWrite        <= 1'b0;
            o_LUI             <= 1'b0;
            o_Misalign        <= 1'b0;
        end else begin
            o_DatoLeido       <= dato_next;
            o_ALU             <= i_ALU;
            o_Extension       <= i_Extension;
            o_RegistroDestino <= i_RegistroDestino;
            o_MemToReg        <= i_MemToReg;
            o_RegWrite        <= i_RegWrite;
            o_LUI             <= i_LUI;
            o_Misalign        <= misalign_next;
        end
    end

`ifdef DEBUG_PORT_EN
    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_READ = 2'd1,
        DBG_DONE = 2'd2
    } dbg_state_t;

    dbg_state_t       state_reg;
    dbg_state_t       state_next;
    logic [NBITS-1:0] dbg_data_reg;
    logic [NBITS-1:0] dbg_data_next;
    logic             dbg_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= DBG_IDLE;
            dbg_addr_reg <= '0;
            dbg_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            dbg_addr_reg <= dbg_addr_next;
            dbg_data_reg <= dbg_data_next;
        end
    end

    // Dropping halt aborts the read: no valid pulse, data register keeps its old value.
    always_comb begin
        state_next    = state_reg;
        dbg_addr_next = dbg_addr_reg;
        dbg_data_next = dbg_data_reg;
        dbg_valid     = 1'b0;
        case (state_reg)
            DBG_IDLE: begin
                if (i_Halt && i_DebugReq) begin
                    state_next    = DBG_READ;
                    dbg_addr_next = i_DebugAddr;
                end
            end
            DBG_READ: begin
                if (!i_Halt) begin
                    state_next = DBG_IDLE;
                end else begin
                    state_next    = DBG_DONE;
                    dbg_data_next = dbg_word;
                end
            end
            DBG_DONE: begin
                dbg_valid  = i_Halt;
                state_next = DBG_IDLE;
            end
            default: state_next = DBG_IDLE;
        endcase
    end

    assign o_DebugData  = dbg_data_reg;
    assign o_DebugValid = dbg_valid;

    logic unused_addr_bits;
    assign unused_addr_bits = ^i_ALU[NBITS-1:ADDR_BITS+2];
`else
    assign o_DebugData  = '0;
    assign o_DebugValid = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{i_ALU[NBITS-1:ADDR_BITS+2], i_Halt, i_DebugReq, i_DebugAddr};
`endif

endmodule

// File: tb/tb_etapa_mem_wb.sv
// Table-driven bench for etapa_mem_wb with a scoreboard queue for the registered MEM/WB outputs,
// plus hand-written debug-port and asynchronous-reset sequences.
module tb_etapa_mem_wb;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_ALU = '0, i_Registro2 = '0, i_Extension = '0, i_PCBranch = '0;
    logic [4:0]  i_RegistroDestino = '0;
    logic        i_Cero = 0, i_Branch = 0, i_NBranch = 0, i_MemWrite = 0, i_MemRead = 0;
    logic [1:0]  i_TamanoFiltro = '0, i_TamanoFiltroL = '0;
    logic        i_ZeroExtend = 0, i_MemToReg = 0, i_RegWrite = 0, i_LUI = 0;
    logic        i_Halt = 0, i_DebugReq = 0;
    logic [7:0]  i_DebugAddr = '0;
    logic        o_PCSrc;
    logic [31:0] o_PCBranch, o_DatoLeido, o_ALU, o_Extension, o_DebugData;
    logic [4:0]  o_RegistroDestino;
    logic        o_MemToReg, o_RegWrite, o_LUI, o_Misalign, o_DebugValid;

    etapa_mem_wb dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ALU(i_ALU), .i_Registro2(i_Registro2),
        .i_RegistroDestino(i_RegistroDestino), .i_Extension(i_Extension),
        .i_PCBranch(i_PCBranch), .i_Cero(i_Cero), .i_Branch(i_Branch), .i_NBranch(i_NBranch),
        .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead), .i_TamanoFiltro(i_TamanoFiltro),
        .i_TamanoFiltroL(i_TamanoFiltroL), .i_ZeroExtend(i_ZeroExtend),
        .i_MemToReg(i_MemToReg), .i_RegWrite(i_RegWrite), .i_LUI(i_LUI),
        .i_Halt(i_Halt), .i_DebugReq(i_DebugReq), .i_DebugAddr(i_DebugAddr),
        .o_PCSrc(o_PCSrc), .o_PCBranch(o_PCBranch), .o_DatoLeido(o_DatoLeido),
        .o_ALU(o_ALU), .o_Extension(o_Extension), .o_RegistroDestino(o_RegistroDestino),
        .o_MemToReg(o_MemToReg), .o_RegWrite(o_RegWrite), .o_LUI(o_LUI),
        .o_Misalign(o_Misalign), .o_DebugData(o_DebugData), .o_DebugValid(o_DebugValid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we, re;
        logic [1:0]  ss, sl;
        logic        zx;
        logic [31:0] alu, r2;
        logic        br, nbr, cero;
        logic [31:0] exp_dato;
        logic        exp_mis, exp_pcsrc;
    } vec_t;

    typedef struct {
        logic [31:0] dato, alu, ext;
        logic [4:0]  rd;
        logic        m2r, rw, lui, mis;
    } exp_t;

    vec_t vecs[23];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t v(logic we, logic re, logic [1:0] ss, logic [1:0] sl, logic zx,
                               logic [31:0] alu, logic [31:0] r2, logic br, logic nbr,
                               logic cero, logic [31:0] ed, logic em, logic ep);
        vec_t t;
        t.we = we; t.re = re; t.ss = ss; t.sl = sl; t.zx = zx; t.alu = alu; t.r2 = r2;
        t.br = br; t.nbr = nbr; t.cero = cero; t.exp_dato = ed; t.exp_mis = em; t.exp_pcsrc = ep;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_MemWrite = 0; i_MemRead = 0; i_Branch = 0; i_NBranch = 0; i_Cero = 0;
        i_TamanoFiltro = 0; i_TamanoFiltroL = 0; i_ZeroExtend = 0; i_ALU = 0; i_Registro2 = 0;
        i_MemToReg = 0; i_RegWrite = 0; i_LUI = 0; i_Extension = 0; i_RegistroDestino = 0;
    endtask

    initial begin
        exp_t e, g;
        // Stores and loads of test-plan items 1, 2, 4 plus half-word, wrap and MemRead=0 cases.
        vecs[0]  = v(1,0,2'd2,2'd0,0,32'h10,  32'h12345678,0,0,0,32'h0,0,0);
        vecs[1]  = v(0,1,2'd0,2'd2,0,32'h10,  32'h0,       0,0,0,32'h12345678,0,0);
        vecs[2]  = v(1,0,2'd2,2'd0,0,32'h04,  32'h0,       0,0,0,32'h0,0,0);
        vecs[3]  = v(1,0,2'd0,2'd0,0,32'h05,  32'h123456AB,0,0,0,32'h0,0,0);
        vecs[4]  = v(0,1,2'd0,2'd0,0,32'h05,  32'h0,       0,0,0,32'hFFFFFFAB,0,0);
        vecs[5]  = v(0,1,2'd0,2'd0,1,32'h05,  32'h0,       0,0,0,32'h000000AB,0,0);
        vecs[6]  = v(0,1,2'd0,2'd2,0,32'h04,  32'h0,       0,0,0,32'h0000AB00,0,0);
        vecs[7]  = v(0,1,2'd0,2'd1,0,32'h04,  32'h0,       0,0,0,32'hFFFFAB00,0,0);
        vecs[8]  = v(0,1,2'd0,2'd1,1,32'h06,  32'h0,       0,0,0,32'h0,0,0);
        vecs[9]  = v(0,0,2'd0,2'd0,0,32'h40,  32'h0,       1,0,1,32'h0,0,1);
        vecs[10] = v(0,0,2'd0,2'd0,0,32'h40,  32'h0,       0,1,1,32'h0,0,0);
        vecs[11] = v(0,0,2'd0,2'd0,0,32'h40,  32'h0,       0,1,0,32'h0,0,1);
        vecs[12] = v(1,0,2'd2,2'd0,0,32'h00,  32'h11223344,0,0,0,32'h0,0,0);
        vecs[13] = v(1,0,2'd1,2'd0,0,32'h03,  32'h0000BEEF,0,0,0,32'h0,1,0);
        vecs[14] = v(0,1,2'd0,2'd2,0,32'h00,  32'h0,       0,0,0,32'h11223344,0,0);
        vecs[15] = v(0,1,2'd0,2'd2,0,32'h02,  32'h0,       0,0,0,32'h0,1,0);
        vecs[16] = v(1,0,2'd1,2'd0,0,32'h02,  32'hCAFEBEEF,0,0,0,32'h0,0,0);
        vecs[17] = v(0,1,2'd0,2'd2,0,32'h00,  32'h0,       0,0,0,32'hBEEF3344,0,0);
        vecs[18] = v(0,1,2'd0,2'd2,0,32'h410, 32'h0,       0,0,0,32'h12345678,0,0);
        vecs[19] = v(0,1,2'd0,2'd0,0,32'h13,  32'h0,       0,0,0,32'h00000012,0,0);
        vecs[20] = v(0,1,2'd0,2'd1,1,32'h12,  32'h0,       0,0,0,32'h00001234,0,0);
        vecs[21] = v(0,0,2'd0,2'd2,0,32'h10,  32'h0,       0,0,0,32'h0,0,0);
        vecs[22] = v(0,1,2'd0,2'd1,0,32'h05,  32'h0,       0,0,0,32'h0,1,0);

        // Reset state
        @(posedge i_clk); #1;
        chk("rst_dato", o_DatoLeido, 32'h0);
        chk("rst_alu", o_ALU, 32'h0);
        chk("rst_regwrite", {31'b0, o_RegWrite}, 32'h0);
        chk("rst_misalign", {31'b0, o_Misalign}, 32'h0);
        chk("rst_dbgvalid", {31'b0, o_DebugValid}, 32'h0);
        chk("rst_dbgdata", o_DebugData, 32'h0);
        @(negedge i_clk); i_reset = 0;

        for (int i = 0; i < 23; i++) begin
            @(negedge i_clk);
            i_MemWrite = vecs[i].we; i_MemRead = vecs[i].re;
            i_TamanoFiltro = vecs[i].ss; i_TamanoFiltroL = vecs[i].sl; i_ZeroExtend = vecs[i].zx;
            i_ALU = vecs[i].alu; i_Registro2 = vecs[i].r2;
            i_Branch = vecs[i].br; i_NBranch = vecs[i].nbr; i_Cero = vecs[i].cero;
            i_Extension = $urandom; i_PCBranch = $urandom; i_RegistroDestino = 5'(i);
            i_MemToReg = i[0]; i_RegWrite = 1'b1; i_LUI = i[1];
            e.dato = vecs[i].exp_dato; e.alu = i_ALU; e.ext = i_Extension; e.rd = i_RegistroDestino;
            e.m2r = i_MemToReg; e.rw = 1'b1; e.lui = i_LUI; e.mis = vecs[i].exp_mis;
            sb.push_back(e);
            #1;
            chk($sformatf("v%0d_pcsrc", i), {31'b0, o_PCSrc}, {31'b0, vecs[i].exp_pcsrc});
            chk($sformatf("v%0d_pcbranch", i), o_PCBranch, i_PCBranch);
            @(posedge i_clk); #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL v%0d_scoreboard: got empty queue expected one entry", i);
            end else begin
                g = sb.pop_front();
                chk($sformatf("v%0d_dato", i), o_DatoLeido, g.dato);
                chk($sformatf("v%0d_misalign", i), {31'b0, o_Misalign}, {31'b0, g.mis});
                chk($sformatf("v%0d_alu", i), o_ALU, g.alu);
                chk($sformatf("v%0d_ext", i), o_Extension, g.ext);
                chk($sformatf("v%0d_rd", i), {27'b0, o_RegistroDestino}, {27'b0, g.rd});
                chk($sformatf("v%0d_ctrl", i), {29'b0, o_MemToReg, o_RegWrite, o_LUI},
                    {29'b0, g.m2r, g.rw, g.lui});
            end
            $display("vec %0d alu=%h dato=%h mis=%b pcsrc=%b", i, vecs[i].alu, o_DatoLeido,
                     o_Misalign, o_PCSrc);
        end

        // Debug port: read word 4; a second request during READ must be ignored.
        @(negedge i_clk); clear_inputs();
        i_Halt = 1; i_DebugReq = 1; i_DebugAddr = 8'd4;
        @(posedge i_clk); #1;
        chk("dbg_valid_read", {31'b0, o_DebugValid}, 32'h0);
        @(negedge i_clk); i_DebugAddr = 8'd0;
        @(posedge i_clk); #1;
`ifdef DEBUG_PORT_EN
        chk("dbg_valid_done", {31'b0, o_DebugValid}, 32'h1);
        chk("dbg_data", o_DebugData, 32'h12345678);
`else
        chk("dbg_valid_off", {31'b0, o_DebugValid}, 32'h0);
        chk("dbg_data_off", o_DebugData, 32'h0);
`endif
        $display("debug read word 4 data=%h valid=%b", o_DebugData, o_DebugValid);
        @(negedge i_clk); i_DebugReq = 0;
        @(posedge i_clk); #1;
        chk("dbg_valid_after", {31'b0, o_DebugValid}, 32'h0);

        // Halt dropped while in READ: no pulse, data keeps the previous word.
        @(negedge i_clk); i_DebugReq = 1; i_DebugAddr = 8'd0;
        @(posedge i_clk); #1;
        @(negedge i_clk); i_Halt = 0; i_DebugReq = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk($sformatf("dbg_abort_valid%0d", k), {31'b0, o_DebugValid}, 32'h0);
`ifdef DEBUG_PORT_EN
            chk($sformatf("dbg_abort_data%0d", k), o_DebugData, 32'h12345678);
`else
            chk($sformatf("dbg_abort_data%0d", k), o_DebugData, 32'h0);
`endif
        end
        $display("debug aborted read data=%h", o_DebugData);

        // Asynchronous reset during a debug read, right after a registered load.
        @(negedge i_clk);
        i_Halt = 1; i_DebugReq = 1; i_DebugAddr = 8'd4;
        i_MemRead = 1; i_TamanoFiltroL = 2'd2; i_ALU = 32'h10; i_RegWrite = 1; i_Extension = 32'h55;
        @(posedge i_clk); #1;
        chk("pre_rst_dato", o_DatoLeido, 32'h12345678);
        #1 i_reset = 1;
        #1;
        chk("arst_dato", o_DatoLeido, 32'h0);
        chk("arst_alu", o_ALU, 32'h0);
        chk("arst_ext", o_Extension, 32'h0);
        chk("arst_regwrite", {31'b0, o_RegWrite}, 32'h0);
        chk("arst_dbgvalid", {31'b0, o_DebugValid}, 32'h0);
        chk("arst_dbgdata", o_DebugData, 32'h0);
        $display("async reset applied dato=%h alu=%h", o_DatoLeido, o_ALU);
        @(negedge i_clk); clear_inputs(); i_DebugReq = 0;
        @(posedge i_clk);
        @(negedge i_clk); i_reset = 0;
        i_MemRead = 1; i_TamanoFiltroL = 2'd2; i_ALU = 32'h10;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk($sformatf("post_rst_dato%0d", k), o_DatoLeido, 32'h12345678);
            chk($sformatf("post_rst_valid%0d", k), {31'b0, o_DebugValid}, 32'h0);
        end
        $display("memory after reset word@0x10=%h", o_DatoLeido);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/etapa_mem_wb.md
Name: etapa_mem_wb

Overview:
MEM stage consumer of the EX/MEM pipeline register: resolves branches, performs sized stores and loads on an internal word-organised data memory, and registers results into the MEM/WB boundary.
Also provides a halted-pipeline debug read port (request/valid handshake) for the debug unit to dump data memory.
Sits between the EX/MEM register and the WB mux.

Parameters:
NBITS, 32, datapath width
REGS, 5, register index width
ADDR_BITS, 8, word-address width; memory depth = 2**ADDR_BITS words

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous reset, active-high
i_ALU  in  NBITS  byte address / ALU result
i_Registro2  in  NBITS  store data
i_RegistroDestino  in  REGS  destination register
i_Extension  in  NBITS  immediate, forwarded for LUI
i_PCBranch  in  NBITS  branch target
i_Cero  in  1  ALU zero flag
i_Branch, i_NBranch  in  1 each  BEQ / BNE
i_MemWrite, i_MemRead  in  1 each  store / load enable
i_TamanoFiltro  in  2  store size: 00 byte, 01 half, 1x word
i_TamanoFiltroL  in  2  load size, same encoding
i_ZeroExtend  in  1  1 = zero-extend loads, 0 = sign-extend
i_MemToReg, i_RegWrite, i_LUI  in  1 each  WB control
i_Halt  in  1  pipeline halted
i_DebugReq  in  1  debug read request
i_DebugAddr  in  ADDR_BITS  debug word address
o_PCSrc  out  1  combinational: (Branch & Cero) | (NBranch & ~Cero)
o_PCBranch  out  NBITS  combinational passthrough of i_PCBranch
o_DatoLeido  out  NBITS  registered filtered load data
o_ALU, o_Extension  out  NBITS  registered
o_RegistroDestino  out  REGS  registered
o_MemToReg, o_RegWrite, o_LUI  out  1  registered
o_Misalign  out  1  registered, one-cycle pulse
o_DebugData  out  NBITS  debug word
o_DebugValid  out  1  one-cycle pulse

Behaviour:
- Reset: all registered outputs = 0; debug FSM = IDLE. Memory contents are not cleared.
- Store, at the edge where i_MemWrite=1. Little-endian; byte lane = addr[1:0].
  - Byte: writes lane addr[1:0] with Registro2[7:0].
  - Half: writes lanes {addr[1],0}+0/1 with Registro2[15:0].
  - Word: writes all lanes. Other lanes are unchanged.
- Load, combinational read of word addr[ADDR_BITS+1:2]:
  - Byte: selects lane addr[1:0]. Half: selects by addr[1].
  - Extends per i_ZeroExtend; result captured in o_DatoLeido at the next edge.
  - With i_MemRead=0, o_DatoLeido = 0.
- Misalign:
  - Condition: half with addr[0]=1, or word with addr[1:0]≠0.
  - Effect: store suppressed, load data = 0, o_Misalign=1 for that cycle. RegWrite is still passed through.
- Latency: every MEM/WB output is 1 cycle after its inputs. A load in cycle N+1 after a store in cycle N to the same address returns the new data.
- Address bits above ADDR_BITS+1 are ignored (wrap).
- Debug FSM:
  - IDLE -> READ when i_Halt & i_DebugReq; latches i_DebugAddr.
  - READ -> DONE: o_DebugData loaded.
  - DONE: o_DebugValid=1 for one cycle, then -> IDLE.
  - Requests while not IDLE are ignored.
  - i_Halt falling in READ or DONE -> IDLE immediately, no valid pulse. o_DebugData holds its last value.
- Simultaneous debug read and pipeline store (not legal while halted): the debug port reads the pre-write word.
- Reset asserted mid-operation: FSM -> IDLE, valid = 0, outputs cleared asynchronously.

Optional Feature:
DEBUG_PORT_EN.
- Defined: debug FSM and ports functional as above.
- Undefined: FSM not built; o_DebugData = 0 and o_DebugValid = 0 constantly; i_Halt, i_DebugReq and i_DebugAddr are ignored.

Test Plan:
1. Store word 0x12345678 @0x10, then load word signed @0x10 -> o_DatoLeido=0x12345678 one cycle later.
2. Store byte 0xAB @0x05, then load byte @0x05:
   - signed -> 0xFFFFFFAB.
   - ZeroExtend=1 -> 0x000000AB.
   - Load word @0x04 -> 0x0000AB00 (given prior 0).
3. Branch=1, Cero=1 -> o_PCSrc=1 same cycle. NBranch=1, Cero=1 -> o_PCSrc=0. NBranch=1, Cero=0 -> o_PCSrc=1.
4. Store half 0xBEEF @0x03 -> memory unchanged, o_Misalign pulses. Load word @0x02 -> data 0, o_Misalign=1.
5. i_Halt=1, i_DebugReq @word 4 (holding 0x12345678) -> o_DebugValid pulses 2 cycles later with o_DebugData=0x12345678. Repeat with i_Halt dropped in READ -> no pulse.
6. Assert i_Reset mid-debug and after a registered load -> all outputs 0 asynchronously. After release, memory still holds 0x12345678 @0x10.
